// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the MISC-V hazard/bypass unit.
package hazard_unit_pkg;

  localparam int unsigned REG_W = 2;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [1:0]       fwd_sel_t;

  localparam reg_idx_t REG_ZERO  = REG_W'(0);
  localparam reg_idx_t FLUSH_REG = REG_W'(3);

  localparam fwd_sel_t FWD_NONE = 2'b00;
  localparam fwd_sel_t FWD_MEM  = 2'b01;
  localparam fwd_sel_t FWD_WB   = 2'b10;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous reset and count enable.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Reset overrides increment; hold once all-ones is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Decode-stage stall/flush detection and operand bypass select, with
// saturating event counters for stall and flush cycles.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rdEX,
  input  logic [REG_W-1:0] rdMEM,
  input  logic [REG_W-1:0] rdWB,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             write_enable_ex,
  input  logic             write_enable_mem,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic ex_wr;
  logic load_use;
  logic redirect;

  // MEM result is newer than WB, so it wins when both match.
  function automatic fwd_sel_t bypass_sel(input reg_idx_t rs,
                                          input reg_idx_t rd_mem,
                                          input logic     we_mem,
                                          input reg_idx_t rd_wb);
    fwd_sel_t sel;
    sel = FWD_NONE;
    if (we_mem && (rd_mem != REG_ZERO) && (rd_mem == rs)) begin
      sel = FWD_MEM;
    end else if ((rd_wb != REG_ZERO) && (rd_wb == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // A store in EX has no destination, so it never hazards or redirects.
  always_comb begin
    ex_wr    = write_enable_ex & ~mem_write;
    load_use = mem_read & ex_wr & (rdEX != REG_ZERO) &
               ((rdEX == rs1) | (rdEX == rs2));
    redirect = ex_wr & (rdEX == FLUSH_REG);
    flush    = redirect;
    stall    = load_use & ~redirect;
  end

  always_comb begin
    fwd_a = bypass_sel(rs1, rdMEM, write_enable_mem, rdWB);
    fwd_b = bypass_sel(rs2, rdMEM, write_enable_mem, rdWB);
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed steps plus random vectors
// against a behavioural model of the hazard, bypass and counter rules.
module tb_hazard_unit;

  localparam int unsigned CNT_W   = 16;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       rs1, rs2, rdEX, rdMEM, rdWB;
  logic             mem_read, mem_write, write_enable_ex, write_enable_mem;
  logic             stall, flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;
  int exp_stall_cnt = 0;
  int exp_flush_cnt = 0;
  int m_stall, m_flush, m_fwd_a, m_fwd_b;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .rs1              (rs1),
    .rs2              (rs2),
    .rdEX             (rdEX),
    .rdMEM            (rdMEM),
    .rdWB             (rdWB),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .write_enable_ex  (write_enable_ex),
    .write_enable_mem (write_enable_mem),
    .stall            (stall),
    .flush            (flush),
    .fwd_a            (fwd_a),
    .fwd_b            (fwd_b),
    .stall_count      (stall_count),
    .flush_count      (flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
    checks++;
    assert (obs === 32'(exp_v)) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int fwd_model(input int rs, input int rd_mem, input int we_mem, input int rd_wb);
    if (we_mem != 0 && rd_mem != 0 && rd_mem == rs) return 1;
    if (rd_wb != 0 && rd_wb == rs) return 2;
    return 0;
  endfunction

  // Reference outputs from the current inputs; reset has no effect here.
  task automatic model_comb();
    int ex_wr, lu;
    ex_wr   = (write_enable_ex && !mem_write) ? 1 : 0;
    m_flush = (ex_wr != 0 && int'(rdEX) == 3) ? 1 : 0;
    lu      = (mem_read && ex_wr != 0 && rdEX != 0 &&
               (rdEX == rs1 || rdEX == rs2)) ? 1 : 0;
    m_stall = (lu != 0 && m_flush == 0) ? 1 : 0;
    m_fwd_a = fwd_model(int'(rs1), int'(rdMEM), int'(write_enable_mem), int'(rdWB));
    m_fwd_b = fwd_model(int'(rs2), int'(rdMEM), int'(write_enable_mem), int'(rdWB));
  endtask

  task automatic model_edge();
    model_comb();
    if (reset) begin
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
    end else begin
      if (m_stall != 0 && exp_stall_cnt < CNT_MAX) exp_stall_cnt++;
      if (m_flush != 0 && exp_flush_cnt < CNT_MAX) exp_flush_cnt++;
    end
  endtask

  task automatic drive(input logic [1:0] a, b, ex, mem, wb,
                       input logic mr, mw, wex, wmem);
    rs1 = a; rs2 = b; rdEX = ex; rdMEM = mem; rdWB = wb;
    mem_read = mr; mem_write = mw; write_enable_ex = wex; write_enable_mem = wmem;
  endtask

  task automatic check_comb(input string tag);
    #1;
    model_comb();
    chk({tag, ".stall"}, 32'(stall), m_stall);
    chk({tag, ".flush"}, 32'(flush), m_flush);
    chk({tag, ".fwd_a"}, 32'(fwd_a), m_fwd_a);
    chk({tag, ".fwd_b"}, 32'(fwd_b), m_fwd_b);
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, ".stall_count"}, 32'(stall_count), exp_stall_cnt);
    chk({tag, ".flush_count"}, 32'(flush_count), exp_flush_cnt);
  endtask

  initial begin
    reset = 1'b1;
    drive(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clock_edge();
    clock_edge();
    check_counts("reset");
    chk("reset.stall_count_zero", 32'(stall_count), 0);

    // Load-use while reset held: combinational path ignores reset
    drive(2'd1, 2'd2, 2'd1, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    check_comb("reset_comb");
    chk("reset_comb.stall_direct", 32'(stall), 1);
    @(negedge clk);
    reset = 1'b0;

    // Load-use stall
    drive(2'd1, 2'd2, 2'd1, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    check_comb("load_use");
    chk("load_use.stall_direct", 32'(stall), 1);
    clock_edge();
    check_counts("load_use");
    chk("load_use.count_one", 32'(stall_count), 1);

    // Control redirect
    drive(2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_comb("redirect");
    chk("redirect.flush_direct", 32'(flush), 1);
    clock_edge();
    check_counts("redirect");
    chk("redirect.count_one", 32'(flush_count), 1);

    // Flush beats load-use; store suppresses; r0 never hazards
    drive(2'd3, 2'd0, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_comb("flush_prio");
    chk("flush_prio.stall_direct", 32'(stall), 0);
    drive(2'd3, 2'd0, 2'd3, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_comb("store_sup");
    chk("store_sup.flush_direct", 32'(flush), 0);
    drive(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_comb("r0_dep");
    chk("r0_dep.stall_direct", 32'(stall), 0);
    clock_edge();
    check_counts("after_prio");

    // Forwarding: MEM vs WB selection
    drive(2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_comb("fwd_split");
    chk("fwd_split.fwd_a_direct", 32'(fwd_a), 1);
    chk("fwd_split.fwd_b_direct", 32'(fwd_b), 2);
    drive(2'd2, 2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    check_comb("fwd_mem_wins");
    chk("fwd_mem_wins.fwd_a_direct", 32'(fwd_a), 1);
    drive(2'd2, 2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    check_comb("fwd_wb_only");
    chk("fwd_wb_only.fwd_a_direct", 32'(fwd_a), 2);
    drive(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_comb("fwd_r0");

    // Random vectors with occasional reset
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 24) == 0);
      drive(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
      check_comb("rand");
      clock_edge();
      check_counts("rand");
    end

    // Saturation: hold a stall past full scale while flush stays nonzero
    @(negedge clk);
    reset = 1'b0;
    drive(2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    clock_edge();
    drive(2'd1, 2'd2, 2'd1, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < CNT_MAX + 4; i++) clock_edge();
    check_counts("saturate");
    chk("saturate.all_ones", 32'(stall_count), CNT_MAX);
    clock_edge();
    chk("saturate.hold", 32'(stall_count), CNT_MAX);

    // Reset for one edge while stall is active
    @(negedge clk);
    reset = 1'b1;
    check_comb("reset_mid");
    clock_edge();
    @(negedge clk);
    reset = 1'b0;
    check_counts("reset_mid");
    chk("reset_mid.stall_zero", 32'(stall_count), 0);
    chk("reset_mid.flush_zero", 32'(flush_count), 0);
    clock_edge();
    check_counts("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Hazard detection and bypass-select unit for the small MISC-V pipeline, between decode and the EX/MEM/WB pipeline registers.
- Combinationally decides, each cycle, whether the decode-stage instruction must stall or the younger pipeline must be flushed.
- Also produces operand bypass selects.
- Keeps registered, saturating stall and flush event counters for debug and performance.

Parameters:
- REG_W, 2, width of register specifiers (4 architectural registers).
- FLUSH_REG, 3, register index whose write from EX redirects control flow (PC/link register).
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high; clears counters only.
- rs1  in  REG_W  decode-stage source register 1.
- rs2  in  REG_W  decode-stage source register 2.
- rdEX  in  REG_W  destination of the EX-stage instruction.
- rdMEM  in  REG_W  destination of the MEM-stage instruction.
- rdWB  in  REG_W  destination of the WB-stage instruction.
- mem_read  in  1  EX-stage instruction is a load.
- mem_write  in  1  EX-stage instruction is a store (no register destination).
- write_enable_ex  in  1  EX-stage instruction writes rdEX.
- write_enable_mem  in  1  MEM-stage instruction writes rdMEM.
- stall  out  1  hold PC and IF/ID, insert bubble into EX.
- flush  out  1  squash IF/ID and ID/EX contents.
- fwd_a  out  2  rs1 bypass select: 00 register file, 01 MEM, 10 WB.
- fwd_b  out  2  rs2 bypass select, same encoding as fwd_a.
- stall_count  out  CNT_W  cycles in which stall was high.
- flush_count  out  CNT_W  cycles in which flush was high.

Behaviour:
- Register 0 is hardwired zero and never creates a dependency or a forward.
- ex_wr = write_enable_ex & ~mem_write. A store in EX suppresses all rdEX-based logic.
- Load-use condition: mem_read & ex_wr & rdEX!=0 & (rdEX==rs1 | rdEX==rs2).
- Flush condition: ex_wr & rdEX==FLUSH_REG. This is independent of mem_read.
- flush = flush condition.
- stall = load-use condition & ~flush. Flush has priority because the dependent younger instruction is squashed anyway. stall and flush are never both 1.
- fwd_a:
  - 01 if write_enable_mem & rdMEM!=0 & rdMEM==rs1;
  - else 10 if rdWB!=0 & rdWB==rs1 (WB always writes a nonzero rdWB);
  - else 00.
  - MEM beats WB.
- fwd_b: same rule using rs2.
- stall, flush, fwd_a and fwd_b are purely combinational: zero latency, valid in the same cycle as the inputs, unaffected by reset.
- Counters:
  - On each rising clk, stall_count increments if stall==1; flush_count increments if flush==1.
  - Each counter saturates at all-ones and does not wrap.
  - reset==1 at an edge clears both to 0, overriding any increment.
  - Reset value of both counters is 0.
  - Reset asserted mid-operation does not alter the combinational outputs.
- No handshakes and no state machine.

Decomposition:
- Shared package holds: REG_W; FLUSH_REG; the fwd encoding constants FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10; REG_ZERO=0.
- One natural sub-module, sat_counter (CNT_W, sync reset, enable, saturate), instantiated twice.
- Detection and forwarding logic stay in the top-level module.

Test Plan:
- Load-use: rs1=01, rs2=10, rdEX=01, rdMEM=00, rdWB=11, mem_read=1, mem_write=0, we_ex=1, we_mem=0 -> stall=1, flush=0, fwd_a=00, fwd_b=00. After one clk, stall_count=1.
- Control redirect: rs1=01, rs2=10, rdEX=11, rdMEM=00, rdWB=00, mem_read=0, mem_write=0, we_ex=1, we_mem=0 -> stall=0, flush=1. After one clk, flush_count=1.
- Priority and suppression:
  - rs1=11, rdEX=11, mem_read=1, we_ex=1 -> flush=1, stall=0.
  - Same with mem_write=1 -> stall=0, flush=0.
  - rs1=00, rdEX=00, mem_read=1 -> stall=0.
- Forwarding:
  - rs1=10, rs2=01, rdMEM=10, we_mem=1, rdWB=01 -> fwd_a=01, fwd_b=10.
  - rdMEM=rdWB=rs1=10, we_mem=1 -> fwd_a=01.
  - Same with we_mem=0 -> fwd_a=10.
- Counters: hold stall=1 for 2^CNT_W+3 cycles -> stall_count=all-ones. Assert reset for one edge while stall=1 -> both counters 0 on the next cycle.
